seg7_capture: RTL and testbench

- Reads back a multiplexed, active-low 7-segment display bus (segment lines plus anode strobes) and recovers the BCD value of each digit.
- It is the receive end of the BCD-to-segment decode path in the refrigeration controller. It lets the controller check what a display, or a remote panel, is actually showing.
- Samples are qualified by anode settle time and by N consecutive identical readings before a digit register updates.

---
 rtl/seg7_capture.sv | 169 ++++++++++++++++
 tb/tb_seg7_capture.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// seg7_capture
// Reads back a multiplexed, active-low 7-segment display bus and recovers the
// BCD code shown on each digit. A digit is sampled once per anode assertion,
// after the anode has been steady for SETTLE_CYCLES, and is committed only
// after STABLE_CNT consecutive identical readings.
//
// Optional feature macro: SEG7_CAPTURE_DASH_EN. When it is defined, the dash
// pattern (only segment g lit) decodes to 4'hA without an error flag.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   seg_in      segment lines, active-low, bit6=g .. bit0=a
//   an_in       anode strobes, active-low, one-hot-low when a digit is driven
//   digits_out  committed codes, digit i at [4i+3:4i]
//   digit_err   per-digit flag, 1 = committed pattern unrecognised
//   update      one-cycle pulse when a committed digit changes
//   update_idx  index of the digit changed in the update cycle
//
// state  | meaning
// IDLE   | waiting for a single low anode
// SETTLE | anode steady, counting settle cycles
// SAMPLE | decode segments and run the stability update
// HOLD   | sample taken, wait for the anode to change
module seg7_capture #(
  parameter int DIGITS        = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int STABLE_CNT    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  update,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] update_idx
);

  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SETW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int STBW = $clog2(STABLE_CNT + 1);
  localparam logic [SETW-1:0] SET_LAST = SETW'(SETTLE_CYCLES - 1);
  localparam logic [STBW-1:0] STB_MAX  = STBW'(STABLE_CNT);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} state_t;

  state_t            state;
  logic [6:0]        seg_s1, seg_s2;
  logic [DIGITS-1:0] an_s1, an_s2, an_lat;
  logic [IDXW-1:0]   lat_idx;
  logic [SETW-1:0]   settle_cnt;
  logic [3:0]        cand_code [DIGITS];
  logic              cand_err  [DIGITS];
  logic [STBW-1:0]   match_cnt [DIGITS];

  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1000000: r = 5'h00;
      7'b1111001: r = 5'h01;
      7'b0100100: r = 5'h02;
      7'b0110000: r = 5'h03;
      7'b0011001: r = 5'h04;
      7'b0010010: r = 5'h05;
      7'b0000010: r = 5'h06;
      7'b1111000: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0010000: r = 5'h09;
      default: begin
`ifdef SEG7_CAPTURE_DASH_EN
        if (p == 7'b0111111) r = 5'h0A;
        else                 r = 5'h1F;
`else
        r = 5'h1F;
`endif
      end
    endcase
    return r;
  endfunction

  logic [DIGITS-1:0] an_low;
  logic              an_valid;
  logic [IDXW-1:0]   an_idx;
  logic [4:0]        dec;
  logic              same;
  logic [STBW-1:0]   next_cnt;
  logic              commit;

  always_comb begin
    an_low   = ~an_s2;
    an_valid = (an_low != '0) && ((an_low & (an_low - DIGITS'(1))) == '0);
    an_idx   = '0;
    for (int i = 0; i < DIGITS; i++)
      if (an_low[i]) an_idx = IDXW'(i);
    dec      = decode(seg_s2);
    same     = (dec == {cand_err[lat_idx], cand_code[lat_idx]});
    if (!same)                             next_cnt = STBW'(1);
    else if (match_cnt[lat_idx] == STB_MAX) next_cnt = STB_MAX;
    else                                   next_cnt = match_cnt[lat_idx] + STBW'(1);
    // Commit only on the transition into saturation, and only if the value is new.
    commit = (next_cnt == STB_MAX) && !(same && match_cnt[lat_idx] == STB_MAX) &&
             (dec != {digit_err[lat_idx], digits_out[int'(lat_idx)*4 +: 4]});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1     <= '1;
      seg_s2     <= '1;
      an_s1      <= '1;
      an_s2      <= '1;
      an_lat     <= '1;
      lat_idx    <= '0;
      settle_cnt <= '0;
      state      <= IDLE;
      digits_out <= '1;
      digit_err  <= '0;
      update     <= 1'b0;
      update_idx <= '0;
      for (int i = 0; i < DIGITS; i++) begin
        cand_code[i] <= 4'hF;
        cand_err[i]  <= 1'b0;
        match_cnt[i] <= '0;
      end
    end else begin
      seg_s1 <= seg_in;
      seg_s2 <= seg_s1;
      an_s1  <= an_in;
      an_s2  <= an_s1;
      update <= 1'b0;
      case (state)
        IDLE: begin
          if (an_valid) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            an_lat     <= an_s2;
            lat_idx    <= an_idx;
          end
        end
        SETTLE: begin
          if (!an_valid || an_s2 != an_lat) state <= IDLE;
          else if (settle_cnt == SET_LAST)  state <= SAMPLE;
          else                              settle_cnt <= settle_cnt + SETW'(1);
        end
        SAMPLE: begin
          if (!an_valid) begin
            state <= IDLE;
          end else begin
            cand_code[lat_idx] <= dec[3:0];
            cand_err[lat_idx]  <= dec[4];
            match_cnt[lat_idx] <= next_cnt;
            if (commit) begin
              digits_out[int'(lat_idx)*4 +: 4] <= dec[3:0];
              digit_err[lat_idx]               <= dec[4];
              update                           <= 1'b1;
              update_idx                       <= lat_idx;
            end
            state <= HOLD;
          end
        end
        HOLD: begin
          if (an_s2 != an_lat) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] digits_out;
  logic [3:0]  digit_err;
  logic        update;
  logic [1:0]  update_idx;

  seg7_capture #(.DIGITS(4), .SETTLE_CYCLES(16), .STABLE_CNT(3)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
    .digits_out(digits_out), .digit_err(digit_err),
    .update(update), .update_idx(update_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int STB = 3;
  localparam logic [6:0] P0 = 7'b1000000, P2 = 7'b0100100, P4 = 7'b0011001,
                         P5 = 7'b0010010, P6 = 7'b0000010, P7 = 7'b1111000,
                         P9 = 7'b0010000, PDASH = 7'b0111111;

  typedef struct { int idx; logic [3:0] code; logic err; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int upd_seen = 0;

  // reference model state
  logic [3:0] m_cand [4];
  logic       m_cerr [4];
  int         m_cnt  [4];
  logic [3:0] m_code [4];
  logic       m_err  [4];
  logic [6:0] cur_pat [4];

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    case (p)
      7'b1000000: return 5'h00;
      7'b1111001: return 5'h01;
      7'b0100100: return 5'h02;
      7'b0110000: return 5'h03;
      7'b0011001: return 5'h04;
      7'b0010010: return 5'h05;
      7'b0000010: return 5'h06;
      7'b1111000: return 5'h07;
      7'b0000000: return 5'h08;
      7'b0010000: return 5'h09;
`ifdef SEG7_CAPTURE_DASH_EN
      7'b0111111: return 5'h0A;
`endif
      default:    return 5'h1F;
    endcase
  endfunction

  function automatic logic [15:0] model_out();
    return {m_code[3], m_code[2], m_code[1], m_code[0]};
  endfunction

  function automatic logic [3:0] model_err();
    return {m_err[3], m_err[2], m_err[1], m_err[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cand[i] = 4'hF; m_cerr[i] = 1'b0; m_cnt[i] = 0;
      m_code[i] = 4'hF; m_err[i] = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic model_sample(input int idx, input logic [6:0] pat);
    logic [4:0] d;
    bit reached;
    exp_t e;
    d = ref_decode(pat);
    reached = 0;
    if (d[3:0] == m_cand[idx] && d[4] == m_cerr[idx]) begin
      if (m_cnt[idx] < STB) begin
        m_cnt[idx]++;
        reached = (m_cnt[idx] == STB);
      end
    end else begin
      m_cand[idx] = d[3:0];
      m_cerr[idx] = d[4];
      m_cnt[idx]  = 1;
      reached = (STB == 1);
    end
    if (reached && (m_code[idx] != d[3:0] || m_err[idx] != d[4])) begin
      m_code[idx] = d[3:0];
      m_err[idx]  = d[4];
      e.idx = idx; e.code = d[3:0]; e.err = d[4];
      exp_q.push_back(e);
    end
  endtask

  // Drive one anode phase of len cycles followed by a short blank gap.
  task automatic visit(input int idx, input logic [6:0] pat, input int len);
    logic [3:0] one;
    one = 4'b0001;
    if (len >= 30) model_sample(idx, pat);
    an_in  = ~(one << idx);
    seg_in = pat;
    repeat (len) @(posedge clk);
    #1;
    an_in  = '1;
    seg_in = '1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    for (int d = 0; d < 4; d++) visit(d, cur_pat[d], 64);
  endtask

  always @(negedge clk) begin
    if (rst_n && update) begin
      exp_t e;
      upd_seen++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_update: idx=%0d digits=%h err=%b, required no pulse",
                 update_idx, digits_out, digit_err);
      end else begin
        e = exp_q.pop_front();
        if (update_idx !== 2'(e.idx) || digits_out[e.idx*4 +: 4] !== e.code ||
            digit_err[e.idx] !== e.err) begin
          n_bad++;
          $display("FAIL update_value: got idx=%0d code=%h err=%b, required idx=%0d code=%h err=%b",
                   update_idx, digits_out[e.idx*4 +: 4], digit_err[e.idx], e.idx, e.code, e.err);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b1;
    an_in = '1;
    seg_in = '1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (digits_out !== 16'hFFFF || digit_err !== 4'h0 || update !== 1'b0 || update_idx !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_values: got digits=%h err=%b upd=%b idx=%0d, required FFFF 0000 0 0",
               digits_out, digit_err, update, update_idx);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_normal_scan();
    int u0;
    u0 = upd_seen;
    cur_pat[0] = P4; cur_pat[1] = P2; cur_pat[2] = P7; cur_pat[3] = P0;
    for (int f = 0; f < 2; f++) frame();
    n_cmp++;
    if (upd_seen != u0 || digits_out !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL scan_early_commit: got %0d updates digits=%h, required 0 updates FFFF",
               upd_seen - u0, digits_out);
    end
    frame();
    n_cmp++;
    if (upd_seen - u0 != 4 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scan_update_count: got %0d pending=%0d, required 4 pending=0",
               upd_seen - u0, exp_q.size());
    end
    n_cmp++;
    if (digits_out !== 16'h0724 || digit_err !== 4'h0) begin
      n_bad++;
      $display("FAIL scan_digits: got %h err=%b, required 0724 err=0000", digits_out, digit_err);
    end
  endtask

  task automatic test_glitch();
    int u0;
    u0 = upd_seen;
    visit(0, cur_pat[0], 64);
    visit(1, P6, 64);
    visit(2, cur_pat[2], 64);
    visit(3, cur_pat[3], 64);
    for (int f = 0; f < 3; f++) frame();
    n_cmp++;
    if (upd_seen != u0 || digits_out !== 16'h0724 || digits_out !== model_out()) begin
      n_bad++;
      $display("FAIL glitch_no_update: got %0d updates digits=%h, required 0 updates 0724",
               upd_seen - u0, digits_out);
    end
  endtask

  task automatic test_short_invalid();
    int u0;
    u0 = upd_seen;
    for (int k = 0; k < 4; k++) visit(0, P9, 10);
    for (int k = 0; k < 4; k++) begin
      an_in = 4'b1001;
      seg_in = P9;
      repeat (64) @(posedge clk);
      #1 an_in = '1;
      repeat (3) @(posedge clk);
      #1;
    end
    n_cmp++;
    if (upd_seen != u0 || digits_out !== model_out() || digit_err !== model_err()) begin
      n_bad++;
      $display("FAIL short_invalid: got %0d updates digits=%h, required 0 updates %h",
               upd_seen - u0, digits_out, model_out());
    end
    // A single long visit now must not complete a 9 on digit 0.
    visit(0, P9, 64);
    n_cmp++;
    if (digits_out[3:0] !== 4'h4) begin
      n_bad++;
      $display("FAIL short_invalid_digit0: got %h, required 4", digits_out[3:0]);
    end
    visit(0, P4, 64);
  endtask

  task automatic test_dash();
    logic [3:0] want_code;
    logic       want_err;
`ifdef SEG7_CAPTURE_DASH_EN
    want_code = 4'hA; want_err = 1'b0;
`else
    want_code = 4'hF; want_err = 1'b1;
`endif
    for (int k = 0; k < 3; k++) visit(2, PDASH, 64);
    cur_pat[2] = PDASH;
    n_cmp++;
    if (digits_out[11:8] !== want_code || digit_err[2] !== want_err || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL dash_digit2: got code=%h err=%b pending=%0d, required code=%h err=%b pending=0",
               digits_out[11:8], digit_err[2], exp_q.size(), want_code, want_err);
    end
    n_cmp++;
    if (digits_out !== model_out() || digit_err !== model_err()) begin
      n_bad++;
      $display("FAIL dash_all: got %h/%b, required %h/%b",
               digits_out, digit_err, model_out(), model_err());
    end
  endtask

  task automatic test_unchanged();
    int u0;
    u0 = upd_seen;
    for (int f = 0; f < 10; f++) frame();
    n_cmp++;
    if (upd_seen != u0) begin
      n_bad++;
      $display("FAIL unchanged_updates: got %0d, required 0", upd_seen - u0);
    end
  endtask

  task automatic test_reset_mid();
    int u0;
    an_in = 4'b1110;
    seg_in = P5;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (digits_out !== 16'hFFFF || digit_err !== 4'h0 || update !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: got digits=%h err=%b upd=%b, required FFFF 0000 0",
               digits_out, digit_err, update);
    end
    repeat (3) @(posedge clk);
    #1 an_in = '1;
    seg_in = '1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    u0 = upd_seen;
    for (int k = 0; k < 2; k++) visit(3, P9, 64);
    n_cmp++;
    if (upd_seen != u0 || digits_out !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL reset_mid_early: got %0d updates digits=%h, required 0 FFFF",
               upd_seen - u0, digits_out);
    end
    visit(3, P9, 64);
    n_cmp++;
    if (upd_seen - u0 != 1 || digits_out !== 16'h9FFF || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL reset_mid_commit: got %0d updates digits=%h, required 1 9FFF",
               upd_seen - u0, digits_out);
    end
  endtask

  initial begin
    test_reset();
    test_normal_scan();
    test_glitch();
    test_short_invalid();
    test_dash();
    test_unchanged();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
